// File: rtl/fp_seq_divider.sv
// Sequential single-precision divider: restoring mantissa divide, one quotient
// bit per clock, with an exponent subtractor alongside it. Denormals flush to
// zero and rounding is truncation. A start/busy/done handshake controls it.
module fp_seq_divider (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [2:0] {IDLE, CALC, NORM, SPEC, DONE} state_t;

  state_t             state, state_next;
  logic               sign_q;
  logic [31:0]        spec_res_q;
  logic               spec_dbz_q;
  logic [23:0]        mb_q;
  logic [25:0]        rem_q;
  logic [24:0]        quo_q;
  logic signed [9:0]  exp_q;
  logic [4:0]         cnt_q;

  // Operand classification on the incoming operands (used only in IDLE)
  logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sign, special;
  logic [31:0] spec_res;
  logic        spec_dbz;

  // Classify operands and resolve the special-case result in priority order
  always_comb begin
    a_zero   = (a[30:23] == 8'h00);
    b_zero   = (b[30:23] == 8'h00);
    a_inf    = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf    = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_nan    = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan    = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    sign     = a[31] ^ b[31];
    special  = a_zero | a_inf | a_nan | b_zero | b_inf | b_nan;
    spec_res = '0;
    spec_dbz = 1'b0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = 32'h7FC0_0000;
    end else if (a_inf) begin
      spec_res = {sign, 31'h7F80_0000};
    end else if (b_zero) begin
      spec_res = {sign, 31'h7F80_0000};
      spec_dbz = 1'b1;
    end else begin
      spec_res = {sign, 31'd0};
    end
  end

  // One restoring-division step and the normalisation of the final quotient
  logic [25:0]       diff, rem_sel, rem_next;
  logic              ge;
  logic signed [9:0] exp_fin;
  logic [22:0]       frac_fin;

  always_comb begin
    ge       = (rem_q >= {2'b00, mb_q});
    diff     = rem_q - {2'b00, mb_q};
    rem_sel  = ge ? diff : rem_q;
    rem_next = rem_sel << 1;
    exp_fin  = quo_q[24] ? exp_q : (exp_q - 10'sd1);
    frac_fin = quo_q[24] ? quo_q[23:1] : quo_q[22:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = special ? SPEC : CALC;
      CALC:    if (cnt_q == 5'd0) state_next = NORM;
      NORM:    state_next = DONE;
      SPEC:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state == CALC) || (state == NORM) || (state == SPEC);
    done = (state == DONE);
  end

  // Datapath: capture on accepted start, iterate in CALC, commit in NORM/SPEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      sign_q      <= 1'b0;
      spec_res_q  <= '0;
      spec_dbz_q  <= 1'b0;
      mb_q        <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      exp_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          div_by_zero <= 1'b0;
          overflow    <= 1'b0;
          underflow   <= 1'b0;
          sign_q      <= sign;
          spec_res_q  <= spec_res;
          spec_dbz_q  <= spec_dbz;
          mb_q        <= {1'b1, b[22:0]};
          rem_q       <= {3'b001, a[22:0]};
          quo_q       <= '0;
          exp_q       <= $signed({2'b00, a[30:23]}) - $signed({2'b00, b[30:23]}) + 10'sd127;
          cnt_q       <= 5'd24;
        end
        // Quotient bits are shifted in MSB first, so after 25 steps bit 24 is the first one decided
        CALC: begin
          rem_q <= rem_next;
          quo_q <= {quo_q[23:0], ge};
          cnt_q <= cnt_q - 5'd1;
        end
        NORM: begin
          if (exp_fin >= 10'sd255) begin
            result   <= {sign_q, 31'h7F80_0000};
            overflow <= 1'b1;
          end else if (exp_fin <= 10'sd0) begin
            result    <= {sign_q, 31'd0};
            underflow <= 1'b1;
          end else begin
            result <= {sign_q, exp_fin[7:0], frac_fin};
          end
        end
        SPEC: begin
          result      <= spec_res_q;
          div_by_zero <= spec_dbz_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_seq_divider.sv
// Randomized plus directed bench for fp_seq_divider against an arithmetic model.
`timescale 1ns/1ps
module tb_fp_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;
  logic        div_by_zero, overflow, underflow;

  int n_vec;
  int n_bad;

  fp_seq_divider dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .div_by_zero(div_by_zero), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: classification rules plus an integer division of the full mantissas
  task automatic model(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic dz, output logic ov,
                       output logic un, output int lat);
    int ea, eb, e;
    logic s, xz, yz, xi, yi, xn, yn;
    logic [47:0] num, q48;
    logic [24:0] q;
    ea = int'(x[30:23]);
    eb = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ea == 0);   yz = (eb == 0);
    xi = (ea == 255) && (x[22:0] == 0);  yi = (eb == 255) && (y[22:0] == 0);
    xn = (ea == 255) && (x[22:0] != 0);  yn = (eb == 255) && (y[22:0] != 0);
    dz = 1'b0; ov = 1'b0; un = 1'b0;
    if (xz || yz || xi || yi || xn || yn) begin
      lat = 2;
      if (xn || yn || (xz && yz) || (xi && yi)) r = 32'h7FC00000;
      else if (xi)                               r = {s, 31'h7F800000};
      else if (yz) begin                         r = {s, 31'h7F800000}; dz = 1'b1; end
      else                                       r = {s, 31'd0};
    end else begin
      lat = 27;
      num = {1'b1, x[22:0], 24'd0};
      q48 = num / {24'd0, 1'b1, y[22:0]};
      q   = q48[24:0];
      e   = ea - eb + 127;
      if (!q[24]) e = e - 1;
      if (e >= 255)     begin r = {s, 31'h7F800000}; ov = 1'b1; end
      else if (e <= 0)  begin r = {s, 31'd0};        un = 1'b1; end
      else r = {s, 8'(e), (q[24] ? q[23:1] : q[22:0])};
    end
  endtask

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input bit intrude);
    logic [31:0] er;
    logic edz, eov, eun;
    int lat, cyc, ndone;
    model(x, y, er, edz, eov, eun, lat);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    cyc = 1;
    check("busy_first", 32'(busy), 32'd1);
    while (!done && cyc < 60) begin
      if (intrude && cyc == 5) begin
        start = 1'b1; a = 32'h40000000; b = 32'h3F800000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("latency", 32'(cyc), 32'(lat));
    check("busy_at_done", 32'(busy), 32'd0);
    check("result", result, er);
    check("div_by_zero", 32'(div_by_zero), 32'(edz));
    check("overflow", 32'(overflow), 32'(eov));
    check("underflow", 32'(underflow), 32'(eun));
    ndone = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("extra_done", 32'(ndone), 32'd0);
  endtask

  function automatic logic [31:0] rand_fp();
    int pick;
    logic [7:0] ex;
    logic [22:0] fr;
    pick = $urandom_range(0, 11);
    fr   = 23'($urandom);
    if (pick == 0)      ex = 8'h00;
    else if (pick == 1) begin ex = 8'hFF; fr = 23'd0; end
    else if (pick == 2) begin ex = 8'hFF; fr = fr | 23'd1; end
    else if (pick == 3) ex = 8'($urandom_range(1, 254));
    else                ex = 8'($urandom_range(64, 190));
    return {1'($urandom), ex, fr};
  endfunction

  initial begin
    int cyc, ndone;
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {29'd0, div_by_zero, overflow, underflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'h40C00000, 32'h40000000, 1'b0);
    check("six_over_two", result, 32'h40400000);
    run_op(32'h3F800000, 32'h40400000, 1'b0);
    check("one_third_trunc", result, 32'h3EAAAAAA);
    run_op(32'hBFC00000, 32'h3F000000, 1'b0);
    run_op(32'h3F800000, 32'h00000000, 1'b0);
    run_op(32'h00000000, 32'h00000000, 1'b0);
    run_op(32'h7F000000, 32'h3E800000, 1'b0);
    run_op(32'h00800000, 32'h40000000, 1'b0);
    run_op(32'h7F800000, 32'h7F800000, 1'b0);
    run_op(32'hFF800000, 32'h3F800000, 1'b0);
    run_op(32'h40490FDB, 32'h7F800000, 1'b0);
    run_op(32'h3F800000, 32'h3FFFFFFF, 1'b0);

    // Reset in the middle of a normal divide
    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_flags", {29'd0, div_by_zero, overflow, underflow}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (cyc = 0; cyc < 35; cyc++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    run_op(32'h40C00000, 32'h40000000, 1'b0);

    // start pulsed while busy must be ignored
    run_op(32'h3F800000, 32'h40400000, 1'b1);
    run_op(32'h3F800000, 32'h00000000, 1'b0);

    for (int i = 0; i < 60; i++) begin
      run_op(rand_fp(), rand_fp(), ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_seq_divider.md
# fp_seq_divider

Sequential IEEE-754 single-precision divider: computes a / b with a restoring mantissa divider (one quotient bit per clock) and an exponent subtractor, the inverse of the multiplier's exponent-sum path. It sits beside the fused array multiplier in the ALU32 floating-point datapath. A start/busy/done handshake controls it. Denormals flush to zero and rounding is truncation.

## Interface
Parameters: none. Fixed single-precision format: 1 sign bit, 8 exponent bits with bias 127, 23 fraction bits.

- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  32  dividend; captured on the accepted start edge
- b  input  32  divisor; captured on the accepted start edge
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse; result and flags are valid from this cycle on
- result  output  32  quotient; held until the next accepted start
- div_by_zero  output  1  set when a is finite non-zero and b is zero
- overflow  output  1  biased exponent ≥ 255 after normalisation; result is ±inf
- underflow  output  1  biased exponent ≤ 0 after normalisation; result is ±0

## Operation
- States: IDLE, CALC, NORM, SPEC, DONE.
  - IDLE→CALC or SPEC when start=1.
  - CALC→NORM after 25 iterations.
  - NORM→DONE.
  - SPEC→DONE.
  - DONE→IDLE.
- Classification, done in IDLE from the incoming operands:
  - exponent 0 = zero (fraction ignored, flush to zero).
  - exponent 255 with fraction 0 = inf; exponent 255 with fraction ≠0 = NaN.
- Special cases go through SPEC. Sign is sa^sb except for NaN. Checks apply in this order:
  - NaN in, 0/0, or inf/inf → 0x7FC00000.
  - a inf → ±inf.
  - b zero → ±inf with div_by_zero=1.
  - a zero or b inf → ±0.
- Normal path:
  - ma = {1,fa}, mb = {1,fb}, each 24 bits.
  - Remainder r (26 bits) starts at ma. For i = 24 down to 0, once per CALC cycle: if r ≥ mb then q[i]=1 and r = r − mb; then r = r<<1.
  - Exponent e = ea − eb + 127, computed 10-bit signed at capture time.
- NORM:
  - q[24]=1 → fraction = q[23:1], exponent = e.
  - q[24]=0 → fraction = q[22:0], exponent = e − 1.
  - Final exponent ≥ 255 → {s,0x7F800000[30:0]}, overflow=1.
  - Final exponent ≤ 0 → {s,31'b0}, underflow=1.
  - Remainder is discarded (truncation).
- Flags are cleared on every accepted start and set only in the SPEC or NORM update.
- start is ignored outside IDLE. There is no queueing.

## Timing
- The accepted start edge ends cycle t.
- Normal path:
  - busy=1 during cycles t+1 through t+26 (CALC t+1..t+25, NORM t+26).
  - result and flags are registered on the edge ending t+26.
  - done=1 in cycle t+27, busy=0.
- Special path:
  - SPEC at t+1, busy=1.
  - done=1 at t+2.
- Earliest back-to-back start: the cycle after done, i.e. in IDLE.
- Reset, asynchronous at any time including mid-CALC:
  - state returns to IDLE.
  - busy, done, result, div_by_zero, overflow, underflow all go to 0.
  - the operation in flight is aborted with no done pulse.
- Operand inputs may change freely after the capture edge.

## Test plan
- 0x40C00000 / 0x40000000 (6.0/2.0) → result 0x40400000, done exactly 27 cycles after the start edge, all flags 0.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAA (truncated, not 0x3EAAAAAB). Also 0xBFC00000 / 0x3F000000 → 0xC0400000.
- 0x3F800000 / 0x00000000 → 0x7F800000 with div_by_zero=1, done at t+2. Also 0/0 → 0x7FC00000 with div_by_zero=0.
- 0x7F000000 / 0x3E800000 → 0x7F800000 with overflow=1. Also 0x00800000 / 0x40000000 → 0x00000000 with underflow=1.
- Assert rst_n=0 at t+10 of a normal divide → all outputs 0 immediately and no done. Then a new start after reset release → correct result 27 cycles later.
- Pulse start again during busy with different operands → ignored; the original result is returned and done pulses exactly once.
